servo_pulse_decoder: RTL and testbench
======================================

Name: servo_pulse_decoder

Overview:
- Receive side of the 50 Hz servo PWM link: measures the high time of an incoming servo pulse (nominal 1–2 ms in a 20 ms frame) and converts it to an 8-bit position, 0..255.
- Inverse of the team's servo PWM generator.
- Sits between an RC receiver or loop-back pin and the drone control logic.
- Flags out-of-range pulses and loss of signal.

Parameters:
- MIN_PULSE, 2500, pulse width in clk cycles that maps to duty 0 (1 ms at 2.5 MHz).
- MAX_PULSE, 5000, pulse width in clk cycles that maps to duty 255 (2 ms).
- GLITCH_CYCLES, 250, high pulses shorter than this are silently ignored.
- MAX_VALID, 7500, high pulses longer than this are errors.
- TIMEOUT_CYCLES, 150000, cycles without an accepted pulse before signal_lost asserts (3 frames).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- pwm_in, input, 1, asynchronous servo pulse input.
- duty, output, 8, last decoded position.
- duty_valid, output, 1, one-cycle strobe when duty updates.
- width, output, 16, raw high-time in cycles of the last accepted pulse.
- pulse_err, output, 1, one-cycle strobe on a rejected over-long pulse.
- signal_lost, output, 1, level: no accepted pulse within TIMEOUT_CYCLES.

Behaviour:
- Clock and reset:
  - Single clock domain; clk is the only clock.
  - rst is synchronous and active-high.
  - Reset values: duty=0, width=0, duty_valid=0, pulse_err=0, signal_lost=1, all counters 0, FSM=ARM, synchronizer flops 0.
- Input conditioning:
  - pwm_in passes through a 2-flop synchronizer, giving s.
  - A registered copy of s, s_d, drives edge detection: rise = s & ~s_d, fall = ~s & s_d.
- FSM states: ARM, WAIT_RISE, HIGH, CALC.
  - ARM: wait until s=0, then go to WAIT_RISE. A pulse already high at reset release is never measured.
  - WAIT_RISE: on rise, hi_cnt <= 1 and go to HIGH.
  - HIGH:
    - While s=1, hi_cnt increments and saturates at MAX_VALID+1. width therefore equals the number of cycles s was sampled high.
    - On fall, classify hi_cnt:
      - hi_cnt < GLITCH_CYCLES: discard with no output; go to WAIT_RISE.
      - hi_cnt > MAX_VALID: pulse_err=1 for the next cycle; go to WAIT_RISE; duty and width unchanged.
      - Otherwise: latch hi_cnt and go to CALC.
  - CALC: compute the position, then return to WAIT_RISE.
- CALC arithmetic:
  - Clamp w = min(max(hi_cnt, MIN_PULSE), MAX_PULSE).
  - num = (w − MIN_PULSE) × 255, 20 bits.
  - duty = floor(num / (MAX_PULSE − MIN_PULSE)), computed by a sequential restoring divider: 1 load cycle plus 20 iterations, one quotient bit per cycle.
  - Quotient is always ≤255; the upper quotient bits are discarded.
- Latency:
  - Let F be the cycle fall is detected.
  - duty, width and duty_valid update in cycle F+22, with duty_valid high for exactly that one cycle.
- Edges while in CALC:
  - Edges arriving during CALC are not tracked.
  - After CALC the FSM returns to WAIT_RISE, and the next full pulse is measured.
  - A pulse whose rise occurred during CALC is not measured. Nominal low time ≥18 ms makes this unreachable in normal operation.
- Timeout:
  - An 18-bit lost_cnt increments every cycle and saturates at TIMEOUT_CYCLES.
  - lost_cnt resets to 0 in the cycle duty_valid asserts.
  - signal_lost = 1 when lost_cnt == TIMEOUT_CYCLES.
  - signal_lost clears in the same cycle duty_valid asserts.
  - duty holds its last value while signal lost.
  - Glitches and error pulses do not reset lost_cnt.
  - A pin stuck high eventually raises signal_lost; its later fall yields pulse_err.
- Reset mid-operation: any state returns to ARM; an in-flight measurement or division is abandoned with no strobe.

Test Plan:
- Nominal:
  - Stimulus: after reset, drive pin low for 1000 cycles, then high for exactly 3750 cycles, then low.
  - Response: duty_valid single cycle; duty=127; width=3750; signal_lost drops to 0 with duty_valid.
  - Check: duty_valid lands 22 cycles after the internal fall detect.
- Endpoints and clamp:
  - High time 2500 → duty=0.
  - High time 5000 → duty=255.
  - High time 1000 → duty=0, width=1000.
  - High time 6000 → duty=255, width=6000.
- Glitch and error:
  - High time 100 → no duty_valid, no pulse_err, duty unchanged.
  - High time 8000 → pulse_err one cycle, no duty_valid, duty and width unchanged.
- Timeout:
  - Stimulus: valid pulse, then pin held low.
  - Response: signal_lost=1 exactly TIMEOUT_CYCLES cycles after duty_valid.
  - Stimulus: next valid pulse of 3000.
  - Response: duty=51, signal_lost=0 in the same cycle.
- Reset cases:
  - Pin high at reset release: no output for that pulse; the following pulse decodes normally.
  - rst asserted during CALC: no duty_valid; duty=0.
- Back-to-back frames: 20 frames of period 50000 cycles with widths sweeping 2500→5000.
  - Response: one duty_valid per frame; each duty equals floor((w−2500)×255/2500); signal_lost stays 0.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : servo_pulse_decoder
// Purpose  : Receive side of the 50 Hz servo PWM link. Measures the high time
//            of each incoming servo pulse and converts it to an 8-bit
//            position (0..255). Flags over-long pulses and loss of signal.
// Ports    : clk            - system clock (only clock)
//            rst            - synchronous active-high reset
//            pwm_in_i       - asynchronous servo pulse input
//            duty_o         - last decoded position
//            duty_valid_o   - one-cycle strobe when duty_o/width_o update
//            width_o        - raw high time (cycles) of last accepted pulse
//            pulse_err_o    - one-cycle strobe on a rejected over-long pulse
//            signal_lost_o  - level, no accepted pulse within TIMEOUT_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module servo_pulse_decoder #(
    parameter int MIN_PULSE      = 2500,
    parameter int MAX_PULSE      = 5000,
    parameter int GLITCH_CYCLES  = 250,
    parameter int MAX_VALID      = 7500,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in_i,
    output logic [7:0]  duty_o,
    output logic        duty_valid_o,
    output logic [15:0] width_o,
    output logic        pulse_err_o,
    output logic        signal_lost_o
);

    localparam logic [15:0] C_MIN     = 16'(MIN_PULSE);
    localparam logic [15:0] C_MAX     = 16'(MAX_PULSE);
    localparam logic [15:0] C_GLITCH  = 16'(GLITCH_CYCLES);
    localparam logic [15:0] C_MAXV    = 16'(MAX_VALID);
    localparam logic [15:0] C_HI_SAT  = 16'(MAX_VALID + 1);
    localparam logic [20:0] C_SPAN    = 21'(MAX_PULSE - MIN_PULSE);
    localparam logic [17:0] C_TIMEOUT = 18'(TIMEOUT_CYCLES);
    localparam logic [4:0]  C_LAST_STEP = 5'd20;

    typedef enum logic [1:0] {
        ST_ARM       = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_CALC      = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic        sync1_q;
    logic        s_q;
    logic        s_dly_q;
    logic [1:0]  arm_cnt_q;
    state_t      state_q;
    logic [15:0] hi_cnt_q;
    logic [15:0] meas_q;
    logic [4:0]  step_q;
    logic [19:0] dvd_q;      // dividend shifting out, quotient shifting in
    logic [19:0] rem_q;
    logic [7:0]  duty_q;
    logic [15:0] width_q;
    logic        dv_q;
    logic        perr_q;
    logic [17:0] lost_cnt_q;
    logic        lost_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        fall;
    logic        rise;
    logic [15:0] w_clamp;
    logic [19:0] num_load;
    logic [20:0] rem_shift;
    logic [20:0] rem_sub;
    logic        q_bit;
    logic [19:0] rem_d;
    logic [19:0] dvd_d;
    logic        finish;

    assign rise = s_q & ~s_dly_q;
    assign fall = ~s_q & s_dly_q;

    always_comb begin
        w_clamp = meas_q;
        if (meas_q < C_MIN) begin
            w_clamp = C_MIN;
        end else if (meas_q > C_MAX) begin
            w_clamp = C_MAX;
        end
    end

    assign num_load = 20'(w_clamp - C_MIN) * 20'd255;

    // Restoring division step. The remainder always stays below the divisor,
    // so the shifted remainder is below twice the divisor and bit 20 of the
    // difference is exactly the borrow of the trial subtraction.
    assign rem_shift = {1'b0, rem_q[19:0]} << 1 | {20'd0, dvd_q[19]};
    assign rem_sub   = rem_shift - C_SPAN;
    assign q_bit     = ~rem_sub[20];
    assign rem_d     = q_bit ? rem_sub[19:0] : rem_shift[19:0];
    assign dvd_d     = {dvd_q[18:0], q_bit};

    assign finish = (state_q == ST_CALC) && (step_q == C_LAST_STEP);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            s_q        <= 1'b0;
            s_dly_q    <= 1'b0;
            arm_cnt_q  <= 2'd0;
            state_q    <= ST_ARM;
            hi_cnt_q   <= 16'd0;
            meas_q     <= 16'd0;
            step_q     <= 5'd0;
            dvd_q      <= 20'd0;
            rem_q      <= 20'd0;
            duty_q     <= 8'd0;
            width_q    <= 16'd0;
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            lost_cnt_q <= 18'd0;
            lost_q     <= 1'b1;
        end else begin
            sync1_q <= pwm_in_i;
            s_q     <= sync1_q;
            s_dly_q <= s_q;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;

            case (state_q)
                // Synchronizer flops are cleared by reset, so s_q does not
                // reflect the pin until two cycles after release. Waiting
                // for the pipeline to fill stops a pin that was already high
                // at release from looking like a fresh rising edge.
                ST_ARM: begin
                    if (arm_cnt_q != 2'd2) begin
                        arm_cnt_q <= arm_cnt_q + 2'd1;
                    end else if (!s_q) begin
                        state_q <= ST_WAIT_RISE;
                    end
                end

                ST_WAIT_RISE: begin
                    if (rise) begin
                        hi_cnt_q <= 16'd1;
                        state_q  <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (s_q) begin
                        if (hi_cnt_q != C_HI_SAT) begin
                            hi_cnt_q <= hi_cnt_q + 16'd1;
                        end
                    end else if (fall) begin
                        if (hi_cnt_q < C_GLITCH) begin
                            state_q <= ST_WAIT_RISE;
                        end else if (hi_cnt_q > C_MAXV) begin
                            perr_q  <= 1'b1;
                            state_q <= ST_WAIT_RISE;
                        end else begin
                            meas_q  <= hi_cnt_q;
                            step_q  <= 5'd0;
                            state_q <= ST_CALC;
                        end
                    end
                end

                // Step 0 loads the scaled numerator, steps 1..20 each
                // produce one quotient bit. The final bit is written
                // straight into duty so the result is visible one cycle
                // after the last iteration.
                ST_CALC: begin
                    if (step_q == 5'd0) begin
                        dvd_q  <= num_load;
                        rem_q  <= 20'd0;
                        step_q <= 5'd1;
                    end else begin
                        dvd_q <= dvd_d;
                        rem_q <= rem_d;
                        if (step_q == C_LAST_STEP) begin
                            duty_q  <= dvd_d[7:0];
                            width_q <= meas_q;
                            dv_q    <= 1'b1;
                            state_q <= ST_WAIT_RISE;
                        end else begin
                            step_q <= step_q + 5'd1;
                        end
                    end
                end

                default: state_q <= ST_ARM;
            endcase

            // Loss-of-signal timer: only accepted pulses restart it.
            if (finish) begin
                lost_cnt_q <= 18'd0;
                lost_q     <= 1'b0;
            end else if (lost_cnt_q != C_TIMEOUT) begin
                lost_cnt_q <= lost_cnt_q + 18'd1;
                if (lost_cnt_q == C_TIMEOUT - 18'd1) begin
                    lost_q <= 1'b1;
                end
            end
        end
    end

    assign duty_o        = duty_q;
    assign duty_valid_o  = dv_q;
    assign width_o       = width_q;
    assign pulse_err_o   = perr_q;
    assign signal_lost_o = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pulse_decoder
// Purpose  : Directed self-checking bench for servo_pulse_decoder, run with
//            a scaled-down timebase (all pulse widths divided by ten).
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pulse_decoder;

    localparam int MINP = 250;
    localparam int MAXP = 500;
    localparam int GL   = 25;
    localparam int MV   = 750;
    localparam int TO   = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm = 1'b0;
    logic [7:0]  duty_o;
    logic        duty_valid_o;
    logic [15:0] width_o;
    logic        pulse_err_o;
    logic        signal_lost_o;

    servo_pulse_decoder #(
        .MIN_PULSE     (MINP),
        .MAX_PULSE     (MAXP),
        .GLITCH_CYCLES (GL),
        .MAX_VALID     (MV),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in_i     (pwm),
        .duty_o       (duty_o),
        .duty_valid_o (duty_valid_o),
        .width_o      (width_o),
        .pulse_err_o  (pulse_err_o),
        .signal_lost_o(signal_lost_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Event monitor, sampled on the falling edge
    int          dv_count   = 0;
    int          dv_cyc     = 0;
    logic [7:0]  dv_duty    = 8'd0;
    logic [15:0] dv_width   = 16'd0;
    logic        dv_lost    = 1'b1;
    int          perr_count = 0;
    logic        sl_prev    = 1'b1;
    int          sl_rise_cyc = -1;

    always @(negedge clk) begin
        if (duty_valid_o) begin
            dv_count = dv_count + 1;
            dv_cyc   = cyc;
            dv_duty  = duty_o;
            dv_width = width_o;
            dv_lost  = signal_lost_o;
        end
        if (pulse_err_o) perr_count = perr_count + 1;
        if (signal_lost_o && !sl_prev) sl_rise_cyc = cyc;
        sl_prev = signal_lost_o;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // High for exactly n cycles; returns the cycle the pin went low.
    task automatic pulse(input int n, output int fall_cyc);
        @(posedge clk);
        #1 pwm = 1'b1;
        repeat (n) @(posedge clk);
        #1 pwm = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pwm = 1'b0;
        idle(4);
        rst = 1'b0;
        tests++; if (duty_o !== 8'd0) begin fails++; $display("FAIL reset_duty got %0d want 0", duty_o); end
        tests++; if (width_o !== 16'd0) begin fails++; $display("FAIL reset_width got %0d want 0", width_o); end
        tests++; if (duty_valid_o !== 1'b0) begin fails++; $display("FAIL reset_dv got %b want 0", duty_valid_o); end
        tests++; if (pulse_err_o !== 1'b0) begin fails++; $display("FAIL reset_perr got %b want 0", pulse_err_o); end
        tests++; if (signal_lost_o !== 1'b1) begin fails++; $display("FAIL reset_lost got %b want 1", signal_lost_o); end
    endtask

    task automatic test_nominal;
        int b, f;
        idle(1000);
        tests++; if (signal_lost_o !== 1'b1) begin fails++; $display("FAIL nom_lost_before got %b want 1", signal_lost_o); end
        b = dv_count;
        pulse(375, f);
        idle(40);
        tests++; if (dv_count != b + 1) begin fails++; $display("FAIL nom_dv_count got %0d want 1", dv_count - b); end
        tests++; if (dv_duty !== 8'd127) begin fails++; $display("FAIL nom_duty got %0d want 127", dv_duty); end
        tests++; if (dv_width !== 16'd375) begin fails++; $display("FAIL nom_width got %0d want 375", dv_width); end
        tests++; if (dv_lost !== 1'b0) begin fails++; $display("FAIL nom_lost_at_dv got %b want 0", dv_lost); end
        // Pin low after edge f, fall seen internally at f+2, strobe at f+2+22
        tests++; if (dv_cyc != f + 24) begin fails++; $display("FAIL nom_latency got %0d want %0d", dv_cyc - f, 24); end
    endtask

    task automatic test_clamp;
        int wv [4] = '{250, 500, 100, 600};
        int ev [4] = '{0, 255, 0, 255};
        int b, f;
        for (int i = 0; i < 4; i++) begin
            idle(100);
            b = dv_count;
            pulse(wv[i], f);
            idle(40);
            tests++; if (dv_count != b + 1) begin fails++; $display("FAIL clamp_dv[%0d] got %0d want 1", wv[i], dv_count - b); end
            tests++; if (dv_duty !== 8'(ev[i])) begin fails++; $display("FAIL clamp_duty[%0d] got %0d want %0d", wv[i], dv_duty, ev[i]); end
            tests++; if (dv_width !== 16'(wv[i])) begin fails++; $display("FAIL clamp_width[%0d] got %0d want %0d", wv[i], dv_width, wv[i]); end
        end
    endtask

    task automatic test_glitch_error;
        int b, p, f;
        // Previous pulse was 600 cycles: duty 255, width 600
        idle(100);
        b = dv_count; p = perr_count;
        pulse(10, f);
        idle(40);
        tests++; if (dv_count != b) begin fails++; $display("FAIL glitch_dv got %0d want 0", dv_count - b); end
        tests++; if (perr_count != p) begin fails++; $display("FAIL glitch_perr got %0d want 0", perr_count - p); end
        tests++; if (duty_o !== 8'd255) begin fails++; $display("FAIL glitch_duty got %0d want 255", duty_o); end
        idle(100);
        pulse(800, f);
        idle(40);
        tests++; if (perr_count != p + 1) begin fails++; $display("FAIL err_perr got %0d want 1", perr_count - p); end
        tests++; if (dv_count != b) begin fails++; $display("FAIL err_dv got %0d want 0", dv_count - b); end
        tests++; if (duty_o !== 8'd255) begin fails++; $display("FAIL err_duty got %0d want 255", duty_o); end
        tests++; if (width_o !== 16'd600) begin fails++; $display("FAIL err_width got %0d want 600", width_o); end
    endtask

    task automatic test_timeout;
        int b, f, v;
        idle(100);
        b = dv_count;
        pulse(375, f);
        idle(40);
        v = dv_cyc;
        tests++; if (dv_count != b + 1) begin fails++; $display("FAIL to_first_dv got %0d want 1", dv_count - b); end
        tests++; if (signal_lost_o !== 1'b0) begin fails++; $display("FAIL to_lost_early got %b want 0", signal_lost_o); end
        sl_rise_cyc = -1;
        idle(TO);
        tests++; if (signal_lost_o !== 1'b1) begin fails++; $display("FAIL to_lost got %b want 1", signal_lost_o); end
        tests++; if (sl_rise_cyc != v + TO) begin fails++; $display("FAIL to_lost_time got %0d want %0d", sl_rise_cyc - v, TO); end
        b = dv_count;
        pulse(300, f);
        idle(40);
        tests++; if (dv_count != b + 1) begin fails++; $display("FAIL to_recover_dv got %0d want 1", dv_count - b); end
        tests++; if (dv_duty !== 8'd51) begin fails++; $display("FAIL to_recover_duty got %0d want 51", dv_duty); end
        tests++; if (dv_lost !== 1'b0) begin fails++; $display("FAIL to_recover_lost_at_dv got %b want 0", dv_lost); end
    endtask

    task automatic test_reset_pin_high;
        int b, p, f;
        idle(100);
        rst = 1'b1;
        pwm = 1'b1;
        idle(4);
        rst = 1'b0;
        b = dv_count; p = perr_count;
        idle(375);
        pwm = 1'b0;
        idle(40);
        tests++; if (dv_count != b) begin fails++; $display("FAIL rsthigh_dv got %0d want 0", dv_count - b); end
        tests++; if (perr_count != p) begin fails++; $display("FAIL rsthigh_perr got %0d want 0", perr_count - p); end
        idle(100);
        pulse(300, f);
        idle(40);
        tests++; if (dv_count != b + 1) begin fails++; $display("FAIL rsthigh_next_dv got %0d want 1", dv_count - b); end
        tests++; if (dv_duty !== 8'd51) begin fails++; $display("FAIL rsthigh_next_duty got %0d want 51", dv_duty); end
    endtask

    task automatic test_reset_in_calc;
        int b, f;
        idle(100);
        b = dv_count;
        pulse(375, f);
        idle(10);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(40);
        tests++; if (dv_count != b) begin fails++; $display("FAIL rstcalc_dv got %0d want 0", dv_count - b); end
        tests++; if (duty_o !== 8'd0) begin fails++; $display("FAIL rstcalc_duty got %0d want 0", duty_o); end
        tests++; if (width_o !== 16'd0) begin fails++; $display("FAIL rstcalc_width got %0d want 0", width_o); end
    endtask

    task automatic test_back_to_back;
        int w, e, b, f;
        idle(100);
        for (int i = 0; i < 20; i++) begin
            w = MINP + (i * (MAXP - MINP)) / 19;
            e = ((w - MINP) * 255) / (MAXP - MINP);
            b = dv_count;
            pulse(w, f);
            idle(2000 - w);
            tests++; if (dv_count != b + 1) begin fails++; $display("FAIL b2b_dv[%0d] got %0d want 1", i, dv_count - b); end
            tests++; if (dv_duty !== 8'(e)) begin fails++; $display("FAIL b2b_duty[%0d] w=%0d got %0d want %0d", i, w, dv_duty, e); end
            tests++; if (signal_lost_o !== 1'b0) begin fails++; $display("FAIL b2b_lost[%0d] got %b want 0", i, signal_lost_o); end
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_clamp;
        test_glitch_error;
        test_timeout;
        test_reset_pin_high;
        test_reset_in_calc;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
